// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first N-bit subtractor (diff = a - b), one bit cell + registered borrow; optional ovf via SERIAL_SUBTRACTOR_OVF_EN.
// Latency: done pulses the cycle after the Nth edge following the accepting edge; busy is high for exactly N clocks.
// Backpressure: start is only sampled while idle; requests during busy are dropped, a back-to-back start on the done cycle is taken.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  sa, sb, sr;
  logic          br;
  logic [CW-1:0] cnt;

  logic          bit_x, bit_y, bit_d, br_nxt, last, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit cell: difference and borrow for the current LSB pair.
  always_comb begin
    busy   = (state == RUN);
    accept = (state == IDLE) && start;
    last   = (state == RUN) && (cnt == LAST);
    bit_x  = sa[0];
    bit_y  = sb[0];
    bit_d  = bit_x ^ bit_y ^ br;
    br_nxt = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & br);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      sr         <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        sa  <= a;
        sb  <= b;
        br  <= 1'b0;
        cnt <= '0;
      end else if (state == RUN) begin
        sa  <= {1'b0, sa[N-1:1]};
        sb  <= {1'b0, sb[N-1:1]};
        sr  <= {bit_d, sr[N-1:1]};
        br  <= br_nxt;
        cnt <= cnt + 1'b1;
        if (last) begin
          diff       <= {bit_d, sr[N-1:1]};
          borrow_out <= br_nxt;
          done       <= 1'b1;
        end
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Operand MSBs are kept separately since sa/sb are shifted away by completion.
  logic a_msb, b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= a[N-1];
        b_msb <= b[N-1];
      end
      if (last) ovf <= (a_msb != b_msb) && (bit_d != a_msb);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor (N = 4) against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int N = 4;
  localparam int MOD = 1 << N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a, b;
  logic         busy, done, borrow_out;
  logic [N-1:0] diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
  logic         prev_ovf;
`endif

  int total = 0;
  int bad   = 0;
  logic [N-1:0] prev_diff;
  logic         prev_borrow;

  serial_subtractor #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int to_signed(input int v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  // Leaves start high if hold is set, so a back-to-back request is already pending.
  task automatic accept(input int ia, input int ib, input bit hold);
    a     = ia[N-1:0];
    b     = ib[N-1:0];
    start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_done(input int ea, input int eb, input bit noise);
    int n;
    int ed, sd;
    bit eborrow, eovf;
    ed      = (ea - eb + MOD) % MOD;
    eborrow = (ea < eb);
    sd      = to_signed(ea) - to_signed(eb);
    eovf    = (sd > MOD / 2 - 1) || (sd < -(MOD / 2));
    n = 0;
    while (!done && n < 3 * N) begin
      chk("busy_during_run", busy, 1);
      chk("diff_stable", diff, prev_diff);
      chk("borrow_stable", borrow_out, prev_borrow);
      if (noise && n == 1) begin
        start = 1'b1;
        a     = N'($urandom);
        b     = N'($urandom);
      end else if (noise && n == 2) begin
        start = 1'b0;
      end
      step();
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    chk("latency", n, N);
    chk("busy_at_done", busy, 0);
    chk("diff", diff, ed);
    chk("borrow_out", borrow_out, eborrow);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("ovf", ovf, eovf);
    prev_ovf = eovf;
`endif
    prev_diff   = ed[N-1:0];
    prev_borrow = eborrow;
  endtask

  task automatic single_op(input int ia, input int ib, input bit noise);
    accept(ia, ib, 1'b0);
    wait_done(ia, ib, noise);
    step();
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    int ra, rb;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    prev_diff   = '0;
    prev_borrow = 1'b0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow_out, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    step();
    rst_n = 1'b1;
    step();
    chk("idle_no_start", busy, 0);

    single_op(7, 3, 1'b0);
    single_op(3, 7, 1'b0);
    single_op(15, 15, 1'b0);
    single_op(0, 0, 1'b0);
    single_op(0, 1, 1'b0);
    single_op(7, 8, 1'b0);

    // Back-to-back: start stays high through the first done cycle.
    accept(9, 2, 1'b1);
    a = 4'd5;
    b = 4'd6;
    wait_done(9, 2, 1'b0);
    step();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_done_clear", done, 0);
    wait_done(5, 6, 1'b0);
    step();
    chk("b2b_done_one_cycle", done, 0);

    // Start pulse mid-run with different operands must be ignored.
    single_op(12, 5, 1'b1);
    repeat (N + 1) begin
      chk("no_second_done", done, 0);
      step();
    end

    // Abort two cycles into an operation.
    accept(11, 4, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow_out, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("abort_ovf", ovf, 0);
    prev_ovf = 1'b0;
`endif
    prev_diff   = '0;
    prev_borrow = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    single_op(6, 9, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = int'($urandom_range(MOD - 1, 0));
      rb = int'($urandom_range(MOD - 1, 0));
      single_op(ra, rb, bit'($urandom_range(1, 0)));
      repeat ($urandom_range(2, 0)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
